sbinit_pattern_gen: RTL and testbench
=====================================

SBINIT_PATTERN_GEN -- requirements
Module: sbinit_pattern_gen

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8000, cycles from request to timeout; used only with SBINIT_TIMEOUT_EN.
REQ-002 Port i_clk  input  1  single clock; all state on its rising edge.
REQ-003 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port i_start_pattern_req  input  1  level request from SBINIT TX FSM; held high until done.
REQ-005 Port i_rx_sb_bit  input  1  received sideband serial bit, one UI per clock.
REQ-006 Port o_tx_sb_bit  output  1  transmitted sideband serial bit.
REQ-007 Port o_tx_sb_valid  output  1  high while a pattern bit is driven.
REQ-008 Port o_pattern_detected  output  1  sticky: partner pattern seen twice consecutively.
REQ-009 Port o_start_pattern_done  output  1  one-cycle completion pulse to SBINIT TX FSM.
REQ-010 Port o_timeout  output  1  one-cycle pulse; present only with SBINIT_TIMEOUT_EN.

Function
REQ-011 One iteration = 64 alternating bits (1,0,...,0; first 1, last 0) then 32 zeros; 96 cycles.
REQ-012 TX FSM states: IDLE, SEND_ALT, SEND_LOW, WAIT_REQ_LOW.
REQ-013 IDLE -> SEND_ALT on req high; first pattern bit (1) appears on o_tx_sb_bit the next cycle.
REQ-014 SEND_ALT: 64 cycles, bit toggles each cycle; then SEND_LOW: 32 cycles of 0; then SEND_ALT again; iterations back-to-back, no gap.
REQ-015 o_tx_sb_valid high in SEND_ALT/SEND_LOW only; o_tx_sb_bit 0 whenever valid is low.
REQ-016 RX checker runs only while req high; ALT phase matches expected toggle starting at 1; mismatch restarts: count=1 if bit is 1, else 0.
REQ-017 After 64 matches, LOW phase counts zeros; a 1 before 32 zeros restarts ALT with count=1.
REQ-018 32 zeros complete one iteration; consecutive count increments (saturating at 2); checker expects 1 next.
REQ-019 A 0 in the cycle after a completed iteration clears the consecutive count to 0.
REQ-020 Consecutive count reaching 2 sets o_pattern_detected the following cycle; held until req low or reset.
REQ-021 After detection, TX completes the iteration in progress plus exactly 4 further full iterations.
REQ-022 On the last SEND_LOW cycle of the 4th extra iteration: o_start_pattern_done pulses for one cycle, FSM enters WAIT_REQ_LOW.
REQ-023 WAIT_REQ_LOW -> IDLE when req low; done never repeats while req stays high.
REQ-024 Req deasserted in any state: next cycle IDLE, valid low, all counters and o_pattern_detected cleared, no done pulse.
REQ-025 Detection and iteration end in the same cycle: that iteration counts as the one in progress.
REQ-026 Bit counter 7 bits, extra-iteration counter 3 bits; neither wraps.

Reset
REQ-027 On i_rst_n low: FSM IDLE, all counters 0, all outputs 0, asynchronously.
REQ-028 Reset mid-pattern aborts silently; after release, a new req rising level restarts from REQ-013.

Configuration
REQ-029 Macro SBINIT_TIMEOUT_EN defined: cycle counter runs from req rise; at TIMEOUT_CYCLES without done, o_timeout pulses once, FSM -> WAIT_REQ_LOW, no done pulse.
REQ-030 Macro undefined: no o_timeout port, no timeout counter; pattern continues until detection or req low.

Verification
REQ-031 Loopback o_tx_sb_bit->i_rx_sb_bit, req high at cycle 0 -> detected after 2nd iteration ends (cycle ~193); done pulse at cycle 576 (6 iterations).
REQ-032 RX fed 63 alternating bits + 32 zeros, repeated -> o_pattern_detected never set; TX keeps sending.
REQ-033 RX: valid iteration, 1 idle zero, valid iteration -> count cleared; detection only after two further back-to-back iterations.
REQ-034 Req dropped at cycle 150 -> valid low at 151, detected 0, no done; re-raise restarts at bit 1.
REQ-035 i_rst_n low at cycle 300 mid-run -> all outputs 0 immediately; recovery per REQ-028.
REQ-036 SBINIT_TIMEOUT_EN, TIMEOUT_CYCLES=500, RX tied 0 -> o_timeout pulse at cycle 500, no done; without macro -> pattern continues indefinitely.

Source files
------------

// File: rtl/sbinit_pattern_gen.sv
// SBINIT sideband pattern generator and partner-pattern checker (64 alternating bits + 32 zeros per iteration).
// Optional timeout path is compiled in with `define SBINIT_TIMEOUT_EN.
module sbinit_pattern_gen #(
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start_pattern_req,
    input  logic i_rx_sb_bit,
    output logic o_tx_sb_bit,
    output logic o_tx_sb_valid,
    output logic o_pattern_detected,
    output logic o_start_pattern_done
`ifdef SBINIT_TIMEOUT_EN
    ,
    output logic o_timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_ALT,
        SEND_LOW,
        WAIT_REQ_LOW
    } tx_state_e;

    if (TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    tx_state_e  state_q, state_d;
    logic [6:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ext_cnt_q, ext_cnt_d;
    logic       armed_q, armed_d;
    logic       done_q, done_d;

    logic       rx_low_q, rx_low_d;
    logic [6:0] rx_cnt_q, rx_cnt_d;
    logic [1:0] consec_q, consec_d;
    logic       just_done_q, just_done_d;
    logic       detected_q, detected_d;

    logic       tx_end;
    logic       det_evt;

`ifdef SBINIT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          timeout_q, timeout_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            ext_cnt_q   <= '0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            rx_low_q    <= 1'b0;
            rx_cnt_q    <= '0;
            consec_q    <= '0;
            just_done_q <= 1'b0;
            detected_q  <= 1'b0;
`ifdef SBINIT_TIMEOUT_EN
            tmr_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            rx_low_q    <= rx_low_d;
            rx_cnt_q    <= rx_cnt_d;
            consec_q    <= consec_d;
            just_done_q <= just_done_d;
            detected_q  <= detected_d;
`ifdef SBINIT_TIMEOUT_EN
            tmr_q       <= tmr_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        armed_d     = armed_q;
        done_d      = 1'b0;
        rx_low_d    = rx_low_q;
        rx_cnt_d    = rx_cnt_q;
        consec_d    = consec_q;
        just_done_d = 1'b0;
        detected_d  = detected_q;
        tx_end      = (state_q == SEND_LOW) && (bit_cnt_q == 7'd31);
        det_evt     = 1'b0;
`ifdef SBINIT_TIMEOUT_EN
        tmr_d       = tmr_q;
        timeout_d   = 1'b0;
`endif

        if (!i_start_pattern_req) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            ext_cnt_d  = '0;
            armed_d    = 1'b0;
            rx_low_d   = 1'b0;
            rx_cnt_d   = '0;
            consec_d   = '0;
            detected_d = 1'b0;
`ifdef SBINIT_TIMEOUT_EN
            tmr_d      = '0;
`endif
        end else begin
            if (!rx_low_q) begin
                if (i_rx_sb_bit == ~rx_cnt_q[0]) begin
                    if (rx_cnt_q == 7'd63) begin
                        rx_low_d = 1'b1;
                        rx_cnt_d = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 7'd1;
                    end
                end else begin
                    rx_cnt_d = {6'd0, i_rx_sb_bit};
                    if (just_done_q) consec_d = '0;
                end
            end else if (i_rx_sb_bit) begin
                rx_low_d = 1'b0;
                rx_cnt_d = 7'd1;
            end else if (rx_cnt_q == 7'd31) begin
                rx_low_d    = 1'b0;
                rx_cnt_d    = '0;
                consec_d    = (consec_q == 2'd2) ? 2'd2 : consec_q + 2'd1;
                just_done_d = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + 7'd1;
            end
            detected_d = detected_q | (consec_q == 2'd2);

            unique case (state_q)
                IDLE: begin
                    state_d   = SEND_ALT;
                    bit_cnt_d = '0;
                end
                SEND_ALT: begin
                    if (bit_cnt_q == 7'd63) begin
                        state_d   = SEND_LOW;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                SEND_LOW: begin
                    if (tx_end) begin
                        state_d   = SEND_ALT;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                default: ;
            endcase

            // ext_cnt counts iteration ends from detection; an end coinciding with detection is the in-progress one.
            det_evt = !armed_q && (consec_d == 2'd2);
            if (det_evt) begin
                armed_d   = 1'b1;
                ext_cnt_d = tx_end ? 3'd1 : 3'd0;
            end else if (armed_q && tx_end) begin
                if (ext_cnt_q == 3'd4) begin
                    done_d    = 1'b1;
                    state_d   = WAIT_REQ_LOW;
                    bit_cnt_d = '0;
                end else begin
                    ext_cnt_d = ext_cnt_q + 3'd1;
                end
            end

`ifdef SBINIT_TIMEOUT_EN
            if (tmr_q != TW'(TIMEOUT_CYCLES)) begin
                tmr_d = tmr_q + 1'b1;
            end else if (!done_d && (state_q == SEND_ALT || state_q == SEND_LOW)) begin
                timeout_d = 1'b1;
                state_d   = WAIT_REQ_LOW;
                bit_cnt_d = '0;
            end
`endif
        end
    end

    always_comb begin
        o_tx_sb_valid        = (state_q == SEND_ALT) || (state_q == SEND_LOW);
        o_tx_sb_bit          = (state_q == SEND_ALT) && !bit_cnt_q[0];
        o_pattern_detected   = detected_q;
        o_start_pattern_done = done_q;
`ifdef SBINIT_TIMEOUT_EN
        o_timeout            = timeout_q;
`endif
    end

endmodule

// File: tb/tb_sbinit_pattern_gen.sv
// Directed testbench for sbinit_pattern_gen: loopback, near-miss patterns, broken runs, req drop, reset, timeout.
module tb_sbinit_pattern_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic loop_en;
    logic rx_drv;
    logic rx_bit;
    logic tx_bit, tx_valid, detected, done;
`ifdef SBINIT_TIMEOUT_EN
    logic timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    assign rx_bit = loop_en ? tx_bit : rx_drv;

    sbinit_pattern_gen #(.TIMEOUT_CYCLES(500)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_start_pattern_req  (req),
        .i_rx_sb_bit          (rx_bit),
        .o_tx_sb_bit          (tx_bit),
        .o_tx_sb_valid        (tx_valid),
        .o_pattern_detected   (detected),
        .o_start_pattern_done (done)
`ifdef SBINIT_TIMEOUT_EN
        ,
        .o_timeout            (timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    function automatic logic exp_tx(input int c);
        int m;
        m = c % 96;
        return (m < 64) && (m % 2 == 0);
    endfunction

    task automatic feed(input int nbits, input int period, input int alt_len);
        for (int j = 0; j < nbits; j++) begin
            rx_drv = ((j % period) < alt_len) && ((j % period) % 2 == 0);
            step();
        end
    endtask

    task automatic go_idle();
        req = 1'b0;
        loop_en = 1'b0;
        rx_drv = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; loop_en = 1'b0; rx_drv = 1'b0;
        #12;
        check("rst_valid", tx_valid, 0);
        check("rst_bit", tx_bit, 0);
        check("rst_det", detected, 0);
        check("rst_done", done, 0);
`ifdef SBINIT_TIMEOUT_EN
        check("rst_timeout", timeout, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        step();

        // Loopback: detection at 193, done pulse at 576, never repeated.
        req = 1'b1; loop_en = 1'b1; cyc = -1;
        for (int c = 0; c < 576; c++) begin
            step();
            check("lb_bit", tx_bit, exp_tx(cyc));
            check("lb_valid", tx_valid, 1);
            check("lb_done", done, 0);
            if (cyc == 192) check("lb_det_early", detected, 0);
            if (cyc == 193) check("lb_det", detected, 1);
        end
        step();
        check("lb_done_pulse", done, 1);
        check("lb_wait_valid", tx_valid, 0);
        check("lb_wait_bit", tx_bit, 0);
        for (int c = 0; c < 20; c++) begin
            step();
            check("lb_done_once", done, 0);
            check("lb_det_held", detected, 1);
        end
        req = 1'b0;
        step();
        check("lb_reqlow_det", detected, 0);
        check("lb_reqlow_valid", tx_valid, 0);
        go_idle();

        // 63 alternating bits + 32 zeros never qualifies.
        req = 1'b1; cyc = -1;
        feed(95 * 4, 95, 63);
        check("near_det", detected, 0);
        check("near_valid", tx_valid, 1);
        check("near_done", done, 0);
        go_idle();

        // Valid iteration, idle zero, then two back-to-back iterations.
        req = 1'b1; cyc = -1;
        feed(96, 96, 64);
        rx_drv = 1'b0;
        step();
        feed(96, 96, 64);
        feed(10, 96, 64);
        check("gap_det_cleared", detected, 0);
        for (int j = 10; j < 96; j++) begin
            rx_drv = (j < 64) && (j % 2 == 0);
            step();
        end
        check("gap_det_pending", detected, 0);
        rx_drv = 1'b1;
        step();
        check("gap_det_set", detected, 1);
        go_idle();

        // Req dropped after detection, then re-raised.
        req = 1'b1; loop_en = 1'b1; cyc = -1;
        run_to(250);
        check("drop_det_before", detected, 1);
        req = 1'b0;
        step();
        check("drop_valid", tx_valid, 0);
        check("drop_det", detected, 0);
        check("drop_done", done, 0);
        step();
        check("drop_idle_valid", tx_valid, 0);
        req = 1'b1; cyc = -1;
        step();
        check("rearm_valid", tx_valid, 1);
        check("rearm_bit0", tx_bit, 1);
        step();
        check("rearm_bit1", tx_bit, 0);
        run_to(192);
        check("rearm_det_early", detected, 0);
        step();
        check("rearm_det", detected, 1);
        go_idle();

        // Asynchronous reset mid-run.
        req = 1'b1; loop_en = 1'b1; cyc = -1;
        run_to(300);
        check("mid_det", detected, 1);
        check("mid_bit", tx_bit, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", tx_valid, 0);
        check("arst_bit", tx_bit, 0);
        check("arst_det", detected, 0);
        check("arst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc = -1;
        step();
        check("rec_valid", tx_valid, 1);
        check("rec_bit", tx_bit, 1);
        go_idle();

        // RX tied low: timeout when enabled, otherwise endless pattern.
        req = 1'b1; rx_drv = 1'b0; cyc = -1;
`ifdef SBINIT_TIMEOUT_EN
        run_to(499);
        check("to_early", timeout, 0);
        check("to_early_valid", tx_valid, 1);
        step();
        check("to_pulse", timeout, 1);
        check("to_done", done, 0);
        check("to_valid", tx_valid, 0);
        step();
        check("to_once", timeout, 0);
`else
        for (int c = 0; c < 700; c++) begin
            step();
            check("norx_bit", tx_bit, exp_tx(cyc));
        end
        check("norx_valid", tx_valid, 1);
        check("norx_det", detected, 0);
        check("norx_done", done, 0);
`endif
        go_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
